fifo_pop_ctrl: RTL

//  Pop-side reader for the parity FIFO: drives pop_grant_o and accepts words from pop_data_i/pop_valid_i.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_pop_ctrl_if.sv | 26 ++
 rtl/fifo_pop_skid.sv | 56 +++++
 rtl/fifo_pop_ctrl.sv | 101 ++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the parity-FIFO pop side.
//   pop_state_e      : reader FSM states
//   MAX_GRANT_PERIOD : upper bound of the grant throttle period
//   parity_ok()      : parity check of a FIFO word, zero-extended to MAX_WORD_W
package fifo_pkg;

    typedef enum logic [1:0] {IDLE, RUN, HALT} pop_state_e;

    localparam int MAX_GRANT_PERIOD = 255;
    localparam int THR_W            = 8;    // holds 0..MAX_GRANT_PERIOD-1
    localparam int MAX_WORD_W       = 256;  // widest FIFO word parity_ok accepts

    // Zero padding does not change the XOR, so any narrower word can be
    // passed in zero-extended.
    function automatic logic parity_ok(input logic [MAX_WORD_W-1:0] word,
                                       input logic                  even_odd);
        return (^word) == even_odd;
    endfunction

endpackage

// File: rtl/fifo_pop_ctrl_if.sv
// Handshake bundle between the parity FIFO, the pop reader and downstream.
//   pop_valid_i/pop_data_i/pop_grant_o : FIFO side (word = parity bit + payload)
//   out_data_o/out_perr_o/out_valid_o/out_ready_i : downstream valid/ready side
// slave  : used by fifo_pop_ctrl
// master : used by whatever drives the FIFO side and consumes the output
interface fifo_pop_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  pop_valid_i;
    logic [DATA_WIDTH:0]   pop_data_i;
    logic                  pop_grant_o;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic                  out_perr_o;
    logic                  out_valid_o;
    logic                  out_ready_i;

    modport slave (
        input  pop_valid_i, pop_data_i, out_ready_i,
        output pop_grant_o, out_data_o, out_perr_o, out_valid_o
    );

    modport master (
        output pop_valid_i, pop_data_i, out_ready_i,
        input  pop_grant_o, out_data_o, out_perr_o, out_valid_o
    );
endinterface

// File: rtl/fifo_pop_skid.sv
// Two-entry in-order buffer for popped words (payload + parity error flag).
//   in_valid/in_data/in_perr : write port, ignored when full
//   out_valid/out_ready/out_data/out_perr : registered read port
//   buf_cnt  : occupancy 0..2
// The head entry drives the outputs directly, so a word written at an edge
// is visible right after that edge.
module fifo_pop_skid #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_perr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_perr,
    output logic [1:0]    buf_cnt
);
    logic [DW-1:0] data_q [2];
    logic          perr_q [2];
    logic          rd_ptr, wr_ptr;
    logic          wr, rd;

    assign wr        = in_valid && (buf_cnt != 2'd2);
    assign rd        = out_valid && out_ready;
    assign out_valid = (buf_cnt != 2'd0);
    assign out_data  = data_q[rd_ptr];
    assign out_perr  = perr_q[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                perr_q[i] <= 1'b0;
            end
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            buf_cnt <= 2'd0;
        end else begin
            if (wr) begin
                data_q[wr_ptr] <= in_data;
                perr_q[wr_ptr] <= in_perr;
                wr_ptr         <= ~wr_ptr;
            end
            if (rd)
                rd_ptr <= ~rd_ptr;
            case ({wr, rd})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end
endmodule

// File: rtl/fifo_pop_ctrl.sv
// Pop-side reader for the parity FIFO.
//   clk, rst    : clock, asynchronous active-high reset
//   enable_i    : 1 lets the reader run, 0 sends it to IDLE
//   err_clr_i   : clears the sticky error and leaves HALT
//   err_o       : sticky parity error
//   bus         : FIFO pop handshake and downstream valid/ready (slave modport)
// Optional build macro FIFO_POP_CTRL_STATS_EN adds word_cnt_o (pop transfers)
// and perr_cnt_o (bad-parity pops); both wrap and ignore err_clr_i.
// Popped words go through a 2-entry buffer; grants are throttled to at most
// one per GRANT_PERIOD cycles and stop in HALT after a bad-parity word.
module fifo_pop_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int EVEN_ODD     = 0,
    parameter int PARITY_BIT   = 0,
    parameter int GRANT_PERIOD = 1,
    parameter int HALT_ON_ERR  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable_i,
    input  logic                err_clr_i,
    output logic                err_o,
`ifdef FIFO_POP_CTRL_STATS_EN
    output logic [31:0]         word_cnt_o,
    output logic [15:0]         perr_cnt_o,
`endif
    fifo_pop_ctrl_if.slave      bus
);
    localparam logic [THR_W-1:0] THR_LOAD = THR_W'(GRANT_PERIOD - 1);

    pop_state_e       state;
    logic [THR_W-1:0] thr_cnt;
    logic [1:0]       buf_cnt;
    logic             pop_xfer;
    logic             pop_perr;

    // Grant depends on registers only, never on pop_valid_i.
    assign bus.pop_grant_o = (state == RUN) && (buf_cnt < 2'd2) && (thr_cnt == '0);
    assign pop_xfer        = bus.pop_grant_o && bus.pop_valid_i;
    assign pop_perr        = (PARITY_BIT != 0) &&
                             !parity_ok(MAX_WORD_W'(bus.pop_data_i), 1'(EVEN_ODD));

    fifo_pop_skid #(.DW(DATA_WIDTH)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (pop_xfer),
        .in_data   (bus.pop_data_i[DATA_WIDTH-1:0]),
        .in_perr   (pop_perr),
        .out_valid (bus.out_valid_o),
        .out_ready (bus.out_ready_i),
        .out_data  (bus.out_data_o),
        .out_perr  (bus.out_perr_o),
        .buf_cnt   (buf_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            thr_cnt <= '0;
            err_o   <= 1'b0;
        end else begin
            if (pop_xfer)
                thr_cnt <= THR_LOAD;
            else if (thr_cnt != '0)
                thr_cnt <= thr_cnt - 1'b1;

            // A bad pop in the same cycle as err_clr_i keeps the error.
            if (pop_xfer && pop_perr)
                err_o <= 1'b1;
            else if (err_clr_i)
                err_o <= 1'b0;

            case (state)
                IDLE: if (enable_i) state <= RUN;
                RUN: begin
                    if (pop_xfer && pop_perr && (HALT_ON_ERR != 0))
                        state <= HALT;
                    else if (!enable_i)
                        state <= IDLE;
                end
                HALT: if (err_clr_i) state <= enable_i ? RUN : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_POP_CTRL_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt_o <= '0;
            perr_cnt_o <= '0;
        end else if (pop_xfer) begin
            word_cnt_o <= word_cnt_o + 32'd1;
            if (pop_perr)
                perr_cnt_o <= perr_cnt_o + 16'd1;
        end
    end
`endif
endmodule
